// File: rtl/memory_access.sv
// Pipeline memory stage: sizes, aligns and issues loads/stores on a valid/ready data bus,
// then returns write-back data or a fault (misaligned, illegal size, conflicting op, timeout).
module memory_access #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   input  logic [31:0] alu_data,
   input  logic [31:0] rt_data,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic        out_fault,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // the requester holds its fields stable from raising valid until that edge.
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  lane_q, lane_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic        out_valid_d, out_fault_d;
   logic [31:0] out_data_d;
   logic        req_d, we_d;
   logic [31:0] addr_d, wdata_d;
   logic [3:0]  wstrb_d;

   logic        is_mem, bad_op, expired;
   logic [3:0]  st_strb;
   logic [31:0] st_data, ld_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign in_ready = (state_q == IDLE);
   assign is_mem   = mem_read | mem_write;
   assign bad_op   = (mem_read & mem_write) || (mem_size == 2'b11) ||
                     (mem_size == 2'b01 && alu_data[0]) ||
                     (mem_size == 2'b10 && alu_data[1:0] != 2'b00);
   assign expired  = (cnt_q == 8'(TIMEOUT - 1));

   always_comb begin
      st_strb = 4'b0000;
      st_data = rt_data;
      case (mem_size)
         2'b00: begin
            st_strb = 4'b0001 << alu_data[1:0];
            st_data = {4{rt_data[7:0]}};
         end
         2'b01: begin
            st_strb = 4'b0011 << {alu_data[1], 1'b0};
            st_data = {2{rt_data[15:0]}};
         end
         default: st_strb = 4'b1111;
      endcase
   end

   // Lane selection uses the address captured at acceptance, not the live input.
   always_comb begin
      ld_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
      ld_half = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
      case (size_q)
         2'b00:   ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
         default: ld_data = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lane_d      = lane_q;
      size_d      = size_q;
      uns_d       = uns_q;
      out_valid_d = 1'b0;
      out_fault_d = 1'b0;
      out_data_d  = '0;
      req_d       = dmem_req;
      we_d        = dmem_we;
      addr_d      = dmem_addr;
      wstrb_d     = dmem_wstrb;
      wdata_d     = dmem_wdata;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (!is_mem) begin
                  out_valid_d = 1'b1;
                  out_data_d  = alu_data;
               end else if (bad_op) begin
                  out_valid_d = 1'b1;
                  out_fault_d = 1'b1;
               end else begin
                  state_d = REQ;
                  cnt_d   = '0;
                  lane_d  = alu_data[1:0];
                  size_d  = mem_size;
                  uns_d   = mem_unsigned;
                  req_d   = 1'b1;
                  we_d    = mem_write;
                  addr_d  = {alu_data[31:2], 2'b00};
                  wstrb_d = mem_write ? st_strb : 4'b0000;
                  wdata_d = st_data;
               end
            end
         end
         REQ: begin
            cnt_d = cnt_q + 8'd1;
            // A bus acceptance in the final allowed cycle wins over the timeout.
            if (dmem_ready) begin
               req_d = 1'b0;
               if (dmem_we) begin
                  out_valid_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  state_d = WAIT;
               end
            end else if (expired) begin
               req_d       = 1'b0;
               out_valid_d = 1'b1;
               out_fault_d = 1'b1;
               state_d     = IDLE;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (dmem_rvalid) begin
               out_valid_d = 1'b1;
               out_data_d  = ld_data;
               state_d     = IDLE;
            end else if (expired) begin
               out_valid_d = 1'b1;
               out_fault_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         lane_q     <= '0;
         size_q     <= '0;
         uns_q      <= 1'b0;
         out_valid  <= 1'b0;
         out_fault  <= 1'b0;
         out_data   <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wstrb <= '0;
         dmem_wdata <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lane_q     <= lane_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         out_valid  <= out_valid_d;
         out_fault  <= out_fault_d;
         out_data   <= out_data_d;
         dmem_req   <= req_d;
         dmem_we    <= we_d;
         dmem_addr  <= addr_d;
         dmem_wstrb <= wstrb_d;
         dmem_wdata <= wdata_d;
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed corner cases plus randomized ops against an arithmetic
// model of sizing, lanes and extension, with a cycle-exact bus responder.
module tb_memory_access;

   logic        clk, rst_n;
   logic        in_valid, in_ready, mem_read, mem_write, mem_unsigned;
   logic [1:0]  mem_size;
   logic [31:0] alu_data, rt_data;
   logic        out_valid, out_fault;
   logic [31:0] out_data;
   logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;

   logic [32:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   memory_access #(.TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
      .mem_unsigned(mem_unsigned), .alu_data(alu_data), .rt_data(rt_data),
      .out_valid(out_valid), .out_data(out_data), .out_fault(out_fault),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Reference model: plain arithmetic over byte counts and lane offsets.
   task automatic model(input logic rd, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] rdata, output logic busop, output logic fault,
                        output logic [31:0] data, output logic [3:0] strb,
                        output logic [31:0] wdata);
      longint nbytes, lane, mask, v;
      nbytes = longint'(1) << size;
      lane   = longint'(addr % 4);
      busop  = 1'b0;
      fault  = 1'b0;
      data   = 32'h0;
      strb   = 4'h0;
      wdata  = 32'h0;
      if (!rd && !wr) begin
         data = addr;
      end else if ((rd && wr) || size == 2'd3 || (longint'(addr) % nbytes) != 0) begin
         fault = 1'b1;
      end else begin
         busop = 1'b1;
         mask  = (longint'(1) << (8 * nbytes)) - 1;
         if (wr) begin
            strb  = 4'(((longint'(1) << nbytes) - 1) << lane);
            wdata = (nbytes == 4) ? rt :
                    (nbytes == 2) ? (rt & 32'hFFFF) * 32'h0001_0001 :
                                    (rt & 32'hFF) * 32'h0101_0101;
         end else begin
            v = (longint'(rdata) >> (8 * lane)) & mask;
            if (!uns && ((v >> (8 * nbytes - 1)) & 1) == 1) v = v | (~mask);
            data = v[31:0];
         end
      end
   endtask

   task automatic check_out();
      logic [32:0] e;
      check("out_valid", {31'b0, out_valid}, 32'd1);
      if (exp_q.size() == 0) begin
         check("exp_q_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check("out_data", out_data, e[31:0]);
         check("out_fault", {31'b0, out_fault}, {31'b0, e[32]});
      end
   endtask

   // Driver: one operation end to end; the bus responder is part of the same sequence.
   task automatic do_op(input logic rd, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] rdata, input int rdly, input int vdly);
      logic busop, ef;
      logic [31:0] ed, ew;
      logic [3:0] es;
      model(rd, wr, size, uns, addr, rt, rdata, busop, ef, ed, es, ew);
      exp_q.push_back({ef, ed});
      check("in_ready", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = size;
      mem_unsigned = uns; alu_data = addr; rt_data = rt;
      @(negedge clk);
      in_valid = 1'b0; alu_data = $urandom; rt_data = $urandom; mem_size = 2'($urandom);
      if (!busop) begin
         check("req_idle", {31'b0, dmem_req}, 32'd0);
         check_out();
      end else begin
         check("req", {31'b0, dmem_req}, 32'd1);
         check("we", {31'b0, dmem_we}, {31'b0, wr});
         check("addr", dmem_addr, {addr[31:2], 2'b00});
         check("wstrb", {28'b0, dmem_wstrb}, {28'b0, es});
         if (wr) check("wdata", dmem_wdata, ew);
         for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check("req_hold", {31'b0, dmem_req}, 32'd1);
            check("addr_hold", dmem_addr, {addr[31:2], 2'b00});
         end
         dmem_ready = 1'b1;
         @(negedge clk);
         dmem_ready = 1'b0;
         check("req_drop", {31'b0, dmem_req}, 32'd0);
         if (wr) begin
            check_out();
         end else begin
            check("no_early_out", {31'b0, out_valid}, 32'd0);
            for (int i = 1; i < vdly; i++) @(negedge clk);
            dmem_rvalid = 1'b1; dmem_rdata = rdata;
            @(negedge clk);
            dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            check_out();
         end
      end
      @(negedge clk);
      check("pulse_end", {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      logic rd, wr, uns;
      logic [1:0] sz;
      logic [31:0] a, amask;
      int m;
      rst_n = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00;
      mem_unsigned = 1'b0; alu_data = '0; rt_data = '0;
      dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_req", {31'b0, dmem_req}, 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_wstrb", {28'b0, dmem_wstrb}, 32'd0);
      check("rst_wdata", dmem_wdata, 32'd0);

      // directed cases
      do_op(0, 0, 2'b10, 0, 32'h1234_5678, 32'h0, 32'h0, 0, 1);
      do_op(0, 1, 2'b00, 0, 32'h0000_0103, 32'hAABB_CCDD, 32'h0, 0, 1);
      do_op(1, 0, 2'b00, 0, 32'h0000_0101, 32'h0, 32'h0000_8000, 0, 1);
      do_op(1, 0, 2'b00, 1, 32'h0000_0101, 32'h0, 32'h0000_8000, 1, 2);
      do_op(1, 0, 2'b01, 0, 32'h0000_0202, 32'h0, 32'h8001_0000, 0, 1);
      do_op(1, 0, 2'b10, 0, 32'h0000_0102, 32'h0, 32'h0, 0, 1);
      do_op(0, 1, 2'b01, 0, 32'h0000_0201, 32'h1, 32'h0, 0, 1);
      do_op(1, 1, 2'b10, 0, 32'h0000_0100, 32'h1, 32'h0, 0, 1);
      do_op(1, 0, 2'b11, 0, 32'h0000_0100, 32'h1, 32'h0, 0, 1);
      do_op(0, 1, 2'b01, 0, 32'h0000_0302, 32'h1234_ABCD, 32'h0, 1, 1);

      // timeout with dmem_ready held low: four REQ cycles, then a fault
      exp_q.push_back({1'b1, 32'h0});
      in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10;
      alu_data = 32'h0000_0400;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("to_req_high", {31'b0, dmem_req}, 32'd1);
         check("to_no_out", {31'b0, out_valid}, 32'd0);
         @(negedge clk);
      end
      check("to_req_low", {31'b0, dmem_req}, 32'd0);
      check_out();
      @(negedge clk);

      // timeout while waiting for read data
      exp_q.push_back({1'b1, 32'h0});
      in_valid = 1'b1; alu_data = 32'h0000_0500;
      @(negedge clk);
      in_valid = 1'b0; dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_out();
      @(negedge clk);

      // reset in WAIT aborts silently; a late rvalid in IDLE is ignored
      in_valid = 1'b1; alu_data = 32'h0000_0600;
      @(negedge clk);
      in_valid = 1'b0; dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_out_valid", {31'b0, out_valid}, 32'd0);
      check("abort_in_ready", {31'b0, in_ready}, 32'd1);
      check("abort_req", {31'b0, dmem_req}, 32'd0);
      dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      check("late_rvalid", {31'b0, out_valid}, 32'd0);
      check("late_in_ready", {31'b0, in_ready}, 32'd1);

      // randomized operations
      for (int n = 0; n < 300; n++) begin
         m  = $urandom_range(0, 9);
         rd = (m >= 2 && m <= 5) || m == 9;
         wr = (m >= 6);
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         uns = 1'($urandom);
         a  = $urandom;
         amask = (sz == 2'b10) ? 32'h3 : (sz == 2'b01) ? 32'h1 : 32'h0;
         if ($urandom_range(0, 9) < 7) a = a & ~amask;
         do_op(rd, wr, sz, uns, a, $urandom, $urandom,
               $urandom_range(0, 1), $urandom_range(1, 2));
      end

      check("exp_q_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
